// File: rtl/cavlc_level_ring_buf_if.sv
// Producer/consumer bus for the CAVLC level ring buffer.
// master drives flush, push and pop requests; slave returns popped data and status.
interface cavlc_level_ring_buf_if #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned LANES     = 2,
    parameter int unsigned NUMW      = 3
);
    logic                         clr;
    logic [NUMW-1:0]              wr_num;
    logic [LANES*DATAWIDTH-1:0]   wr_data;
    logic [NUMW-1:0]              rd_num;
    logic [LANES*DATAWIDTH-1:0]   rd_data;
    logic [LANES-1:0]             rd_valid;
    logic [ADDRWIDTH:0]           count;
    logic                         full;
    logic                         empty;
    logic                         ovf_err;
    logic                         udf_err;

    modport master (
        output clr, wr_num, wr_data, rd_num,
        input  rd_data, rd_valid, count, full, empty, ovf_err, udf_err
    );

    modport slave (
        input  clr, wr_num, wr_data, rd_num,
        output rd_data, rd_valid, count, full, empty, ovf_err, udf_err
    );
endinterface

// File: rtl/cavlc_level_ring_buf.sv
// Multi-lane circular buffer for CAVLC level values.
// Up to LANES pushes and pops per cycle, all-or-nothing acceptance, registered pop data,
// sticky overflow/underflow flags and a synchronous flush.
module cavlc_level_ring_buf #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LANES     = 2,
    parameter int unsigned NUMW      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cavlc_level_ring_buf_if.slave bus
);
    localparam int unsigned CW = ADDRWIDTH + 1;

    logic [DATAWIDTH-1:0]       mem_q [DEPTH];
    logic [ADDRWIDTH-1:0]       wptr_q, wptr_d;
    logic [ADDRWIDTH-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [LANES*DATAWIDTH-1:0] rd_data_q, rd_data_d;
    logic [LANES-1:0]           rd_valid_q, rd_valid_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;

    logic                       push_ok, pop_ok;
    logic                       push_en, pop_en;
    logic [ADDRWIDTH-1:0]       wr_addr [LANES];
    logic [ADDRWIDTH-1:0]       rd_addr [LANES];
    logic [LANES-1:0]           wr_en;

    // Acceptance uses the pre-cycle count only, so a same-cycle pop never frees space
    // and a same-cycle push can never be popped.
    always_comb begin
        push_ok = (32'(bus.wr_num) <= LANES) && (32'(bus.wr_num) <= DEPTH - 32'(count_q));
        pop_ok  = (32'(bus.rd_num) <= LANES) && (32'(bus.rd_num) <= 32'(count_q));
        push_en = push_ok && !bus.clr;
        pop_en  = pop_ok && !bus.clr;
    end

    // Per-lane addresses; truncation to ADDRWIDTH gives the wrap from DEPTH-1 to 0.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            wr_addr[i] = wptr_q + ADDRWIDTH'(i);
            rd_addr[i] = rptr_q + ADDRWIDTH'(i);
            wr_en[i]   = push_en && (i < 32'(bus.wr_num));
        end
    end

    // Next-state for pointers, occupancy, pop data and sticky errors.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        rd_data_d  = '0;
        rd_valid_d = '0;
        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_en) begin
                wptr_d = wptr_q + ADDRWIDTH'(bus.wr_num);
            end
            if (pop_en) begin
                rptr_d = rptr_q + ADDRWIDTH'(bus.rd_num);
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (i < 32'(bus.rd_num)) begin
                        // Reads see memory before this cycle's write: no bypass.
                        rd_data_d[i*DATAWIDTH +: DATAWIDTH] = mem_q[rd_addr[i]];
                        rd_valid_d[i]                       = 1'b1;
                    end
                end
            end
            count_d = count_q + (push_en ? CW'(bus.wr_num) : CW'(0))
                              - (pop_en  ? CW'(bus.rd_num) : CW'(0));
            ovf_d   = ovf_q | ~push_ok;
            udf_d   = udf_q | ~pop_ok;
        end
    end

    // State and storage registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_addr[i]] <= bus.wr_data[i*DATAWIDTH +: DATAWIDTH];
                end
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Flags decode straight from the count register.
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == CW'(DEPTH));
    assign bus.empty    = (count_q == '0);
    assign bus.ovf_err  = ovf_q;
    assign bus.udf_err  = udf_q;
endmodule

// File: tb/tb_cavlc_level_ring_buf.sv
// Self-checking bench for cavlc_level_ring_buf: directed plan steps plus random traffic,
// compared against a queue-based model of the buffer contents.
module tb_cavlc_level_ring_buf;
    localparam int unsigned DATAWIDTH = 16;
    localparam int unsigned ADDRWIDTH = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned LANES     = 2;
    localparam int unsigned NUMW      = 3;

    logic clk;
    logic rst_n;

    cavlc_level_ring_buf_if #(
        .DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH), .LANES(LANES), .NUMW(NUMW)
    ) bus ();

    cavlc_level_ring_buf #(
        .DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH),
        .LANES(LANES), .NUMW(NUMW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer contents as a FIFO queue plus expected registered outputs.
    logic [DATAWIDTH-1:0]       m_q[$];
    logic [LANES*DATAWIDTH-1:0] exp_rd_data;
    logic [LANES-1:0]           exp_rd_valid;
    logic                       exp_ovf;
    logic                       exp_udf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = '0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    64'(bus.count),    64'(m_q.size()));
        check({tag, ".full"},     64'(bus.full),     64'(m_q.size() == DEPTH));
        check({tag, ".empty"},    64'(bus.empty),    64'(m_q.size() == 0));
        check({tag, ".ovf"},      64'(bus.ovf_err),  64'(exp_ovf));
        check({tag, ".udf"},      64'(bus.udf_err),  64'(exp_udf));
        check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(exp_rd_valid));
        check({tag, ".rd_data"},  64'(bus.rd_data),  64'(exp_rd_data));
    endtask

    // One clock: drive requests, let the edge happen, advance the model, check outputs.
    task automatic cycle(input logic c, input int wn, input logic [31:0] wd, input int rn,
                         input string tag);
        int pre;
        bus.clr     = c;
        bus.wr_num  = NUMW'(wn);
        bus.wr_data = wd;
        bus.rd_num  = NUMW'(rn);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            pre          = m_q.size();
            exp_rd_data  = '0;
            exp_rd_valid = '0;
            if (rn <= int'(LANES) && rn <= pre) begin
                for (int i = 0; i < rn; i++) begin
                    exp_rd_data[i*DATAWIDTH +: DATAWIDTH] = m_q.pop_front();
                    exp_rd_valid[i] = 1'b1;
                end
            end else begin
                exp_udf = 1'b1;
            end
            if (wn <= int'(LANES) && wn <= int'(DEPTH) - pre) begin
                for (int i = 0; i < wn; i++) begin
                    m_q.push_back(wd[i*DATAWIDTH +: DATAWIDTH]);
                end
            end else begin
                exp_ovf = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.clr     = 1'b0;
        bus.wr_num  = '0;
        bus.wr_data = '0;
        bus.rd_num  = '0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.empty_const", 64'(bus.empty), 64'd1);
        rst_n = 1'b1;

        // Basic push 2 / pop 2.
        cycle(1'b0, 2, 32'h0022_0011, 0, "push2");
        cycle(1'b0, 0, 32'h0, 2, "pop2");
        check("pop2.data_const", 64'(bus.rd_data), 64'h0022_0011);
        check("pop2.valid_const", 64'(bus.rd_valid), 64'h3);

        // Fill to full, overflow, then pop.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 2, {16'(2*k+2), 16'(2*k+1)}, 0, "fill");
        end
        check("fill.full_const", 64'(bus.full), 64'd1);
        cycle(1'b0, 1, 32'h0000_0063, 0, "ovf_push");
        check("ovf.count_const", 64'(bus.count), 64'd16);
        check("ovf.flag_const", 64'(bus.ovf_err), 64'd1);
        cycle(1'b0, 0, 32'h0, 2, "pop_after_full");
        check("pop_after_full.data_const", 64'(bus.rd_data), 64'h0002_0001);

        // Flush, then walk both pointers to 15 and straddle the wrap.
        cycle(1'b1, 0, 32'h0, 0, "clr1");
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 1, 32'(k + 'h100), 0, "walk_push");
            cycle(1'b0, 0, 32'h0, 1, "walk_pop");
        end
        cycle(1'b0, 2, 32'h000B_000A, 0, "wrap_push");
        cycle(1'b0, 0, 32'h0, 2, "wrap_pop");
        check("wrap.data_const", 64'(bus.rd_data), 64'h000B_000A);

        // Underflow then a legal single pop.
        cycle(1'b0, 1, 32'h0000_0777, 0, "udf_push");
        cycle(1'b0, 0, 32'h0, 2, "udf_pop");
        check("udf.flag_const", 64'(bus.udf_err), 64'd1);
        cycle(1'b0, 0, 32'h0, 1, "pop1");
        check("pop1.data_const", 64'(bus.rd_data), 64'h0000_0777);

        // Simultaneous push/pop at count 3, then at count 0.
        cycle(1'b0, 2, 32'h0302_0301, 0, "sim_fill_a");
        cycle(1'b0, 1, 32'h0000_0303, 0, "sim_fill_b");
        cycle(1'b0, 2, 32'h0305_0304, 1, "sim_pp3");
        check("sim_pp3.data_const", 64'(bus.rd_data), 64'h0000_0301);
        cycle(1'b0, 0, 32'h0, 2, "sim_drain_a");
        cycle(1'b0, 0, 32'h0, 2, "sim_drain_b");
        cycle(1'b0, 2, 32'h0402_0401, 1, "sim_pp0");
        check("sim_pp0.count_const", 64'(bus.count), 64'd2);

        // count=5 with ovf set, then clr with a push in the same cycle.
        cycle(1'b0, 2, 32'h0504_0503, 0, "pre_clr_a");
        cycle(1'b0, 1, 32'h0000_0505, 0, "pre_clr_b");
        cycle(1'b0, 3, 32'h0607_0606, 0, "pre_clr_ovf");
        cycle(1'b1, 2, 32'h0707_0706, 0, "clr_push");
        check("clr_push.count_const", 64'(bus.count), 64'd0);

        // Random traffic, including over-wide requests and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) == 0), int'($urandom_range(0, 4)), $urandom,
                  int'($urandom_range(0, 4)), "rand");
        end

        // Mid-stream asynchronous reset.
        cycle(1'b0, 2, 32'h0902_0901, 0, "pre_rst");
        cycle(1'b0, 2, 32'h0904_0903, 1, "pre_rst2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rst_n = 1'b1;
        cycle(1'b0, 1, 32'h0000_0A01, 0, "post_rst_push");
        cycle(1'b0, 0, 32'h0, 1, "post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
